dht_roof_ctrl: RTL and testbench

//  Consumes the 8-bit temperature/humidity readings from the DHT11 reader.

---
 rtl/dht_roof_pkg.sv | 55 +++++
 rtl/dht_avg_window.sv | 46 ++++
 rtl/dht_roof_ctrl.sv | 144 ++++++++++++++
 tb/tb_dht_roof_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_roof_pkg.sv
// Shared definitions for the DHT11-driven roof controller: default thresholds,
// timing constants, sample widths and the FSM state encodings.
package dht_roof_pkg;

  localparam int unsigned SMP_W        = 8;
  localparam int unsigned AVG_LOG2_DEF = 2;

  localparam logic [7:0]  TEMP_OPEN_DEF  = 8'd20;
  localparam logic [7:0]  TEMP_CLOSE_DEF = 8'd15;
  localparam logic [7:0]  HUMI_OPEN_DEF  = 8'd70;
  localparam logic [7:0]  HUMI_CLOSE_DEF = 8'd85;

  localparam logic [31:0] STALE_CYC_DEF  = 32'd250_000_000;
  localparam logic [31:0] MOTOR_TO_DEF   = 32'd500_000_000;
  localparam logic [31:0] DEAD_CYC_DEF   = 32'd5_000_000;

  // Cycles spent in INIT before the limit switches are trusted
  localparam logic [31:0] INIT_CYC       = 32'd3;

  // Externally visible state code on o_state
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_CLOSED  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_OPENING = 3'd3,
    ST_CLOSING = 3'd4,
    ST_STOP    = 3'd5,
    ST_FAULT   = 3'd6
  } roof_state_e;

  // One-hot internal FSM state
  typedef enum logic [6:0] {
    FSM_INIT    = 7'b000_0001,
    FSM_CLOSED  = 7'b000_0010,
    FSM_OPEN    = 7'b000_0100,
    FSM_OPENING = 7'b000_1000,
    FSM_CLOSING = 7'b001_0000,
    FSM_STOP    = 7'b010_0000,
    FSM_FAULT   = 7'b100_0000
  } roof_fsm_e;

  // Map the one-hot state onto its external code
  function automatic roof_state_e state_code(input roof_fsm_e s);
    case (s)
      FSM_INIT:    state_code = ST_INIT;
      FSM_CLOSED:  state_code = ST_CLOSED;
      FSM_OPEN:    state_code = ST_OPEN;
      FSM_OPENING: state_code = ST_OPENING;
      FSM_CLOSING: state_code = ST_CLOSING;
      FSM_STOP:    state_code = ST_STOP;
      default:     state_code = ST_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/dht_avg_window.sv
// Sliding-window mean of one 8-bit sensor channel. A circular buffer holds the
// last 2**AVG_LOG2 samples and a running sum is kept as sum + new - oldest.
module dht_avg_window
  import dht_roof_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [SMP_W-1:0] i_data,
  output logic [SMP_W-1:0] o_avg,
  output logic             o_full
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = SMP_W + AVG_LOG2;

  logic [SMP_W-1:0]    samp_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_nxt;

  // Slot at wr_ptr is the oldest sample; it is replaced by the new one
  always_comb begin
    sum_nxt = sum_q + SUM_W'(i_data) - SUM_W'(samp_q[wr_ptr]);
  end

  // Buffer, running sum and registered mean update on each strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) samp_q[i] <= '0;
      wr_ptr <= '0;
      sum_q  <= '0;
      o_avg  <= '0;
      o_full <= 1'b0;
    end else if (i_valid) begin
      samp_q[wr_ptr] <= i_data;
      wr_ptr         <= wr_ptr + AVG_LOG2'(1);
      sum_q          <= sum_nxt;
      o_avg          <= SMP_W'(sum_nxt >> AVG_LOG2);
      if (&wr_ptr) o_full <= 1'b1;
    end
  end

endmodule

// File: rtl/dht_roof_ctrl.sv
// Roof controller: averages DHT11 readings, decides open/close with hysteresis
// and drives the roof motor through a limit-switch-guarded FSM with a reversal
// dead time, stale-data fail-safe and motion timeout fault.
module dht_roof_ctrl
  import dht_roof_pkg::*;
#(
  parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
  parameter logic [7:0]  TEMP_OPEN  = TEMP_OPEN_DEF,
  parameter logic [7:0]  TEMP_CLOSE = TEMP_CLOSE_DEF,
  parameter logic [7:0]  HUMI_OPEN  = HUMI_OPEN_DEF,
  parameter logic [7:0]  HUMI_CLOSE = HUMI_CLOSE_DEF,
  parameter logic [31:0] STALE_CYC  = STALE_CYC_DEF,
  parameter logic [31:0] MOTOR_TO   = MOTOR_TO_DEF,
  parameter logic [31:0] DEAD_CYC   = DEAD_CYC_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_temp,
  input  logic [7:0] i_humi,
  input  logic       i_valid,
  input  logic       i_lim_open,
  input  logic       i_lim_closed,
  output logic       o_motor_open,
  output logic       o_motor_close,
  output logic [7:0] o_avg_temp,
  output logic [7:0] o_avg_humi,
  output logic       o_avg_valid,
  output logic       o_stale,
  output logic       o_fault,
  output logic [2:0] o_state
);

  logic        lim_open_m, lim_open_s;
  logic        lim_closed_m, lim_closed_s;
  logic        temp_full, humi_full;
  logic [31:0] stale_cnt;
  logic        want_close, want_open;
  roof_fsm_e   state, nxt;
  logic [31:0] tmr;

  // Two-flop synchronisers for the asynchronous limit switches
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lim_open_m   <= 1'b0;
      lim_open_s   <= 1'b0;
      lim_closed_m <= 1'b0;
      lim_closed_s <= 1'b0;
    end else begin
      lim_open_m   <= i_lim_open;
      lim_open_s   <= lim_open_m;
      lim_closed_m <= i_lim_closed;
      lim_closed_s <= lim_closed_m;
    end
  end

  dht_avg_window #(.AVG_LOG2(AVG_LOG2)) u_temp_win (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_temp),
    .o_avg   (o_avg_temp),
    .o_full  (temp_full)
  );

  dht_avg_window #(.AVG_LOG2(AVG_LOG2)) u_humi_win (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_humi),
    .o_avg   (o_avg_humi),
    .o_full  (humi_full)
  );

  // Both channels fill on the same strobes; the AND keeps them tied together
  assign o_avg_valid = temp_full & humi_full;

  // Cycles since the last reading, saturating at the stale limit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                   stale_cnt <= '0;
    else if (i_valid)               stale_cnt <= '0;
    else if (stale_cnt != STALE_CYC) stale_cnt <= stale_cnt + 32'd1;
  end

  assign o_stale = (stale_cnt == STALE_CYC);

  // Open/close requests with hysteresis; closing always wins
  always_comb begin
    want_close = o_stale |
                 (o_avg_valid & ((o_avg_humi >= HUMI_CLOSE) | (o_avg_temp <= TEMP_CLOSE)));
    want_open  = ~want_close & o_avg_valid &
                 (o_avg_humi <= HUMI_OPEN) & (o_avg_temp >= TEMP_OPEN);
  end

  // Next-state selection; contradictory limit switches override everything after INIT
  always_comb begin
    nxt = state;
    case (state)
      FSM_INIT: begin
        if (tmr == INIT_CYC - 32'd1) begin
          if (lim_closed_s)    nxt = FSM_CLOSED;
          else if (lim_open_s) nxt = FSM_OPEN;
          else                 nxt = FSM_CLOSING;
        end
      end
      FSM_CLOSED:  if (want_open)  nxt = FSM_OPENING;
      FSM_OPEN:    if (want_close) nxt = FSM_CLOSING;
      FSM_OPENING: begin
        if (lim_open_s)                    nxt = FSM_OPEN;
        else if (want_close)               nxt = FSM_STOP;
        else if (tmr == MOTOR_TO - 32'd1)  nxt = FSM_FAULT;
      end
      FSM_CLOSING: begin
        if (lim_closed_s)                  nxt = FSM_CLOSED;
        else if (tmr == MOTOR_TO - 32'd1)  nxt = FSM_FAULT;
      end
      FSM_STOP:    if (tmr == DEAD_CYC - 32'd1) nxt = FSM_CLOSING;
      FSM_FAULT:   nxt = FSM_FAULT;
      default:     nxt = FSM_FAULT;
    endcase
    if ((state != FSM_INIT) && (state != FSM_FAULT) && lim_open_s && lim_closed_s)
      nxt = FSM_FAULT;
  end

  // State, motion timer and registered outputs all derive from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= FSM_INIT;
      tmr           <= '0;
      o_motor_open  <= 1'b0;
      o_motor_close <= 1'b0;
      o_fault       <= 1'b0;
      o_state       <= ST_INIT;
    end else begin
      state <= nxt;
      if (nxt != state)  tmr <= '0;
      else if (tmr != '1) tmr <= tmr + 32'd1;
      o_motor_open  <= (nxt == FSM_OPENING);
      o_motor_close <= (nxt == FSM_CLOSING);
      o_fault       <= (nxt == FSM_FAULT);
      o_state       <= state_code(nxt);
    end
  end

endmodule

// File: tb/tb_dht_roof_ctrl.sv
// Bench for dht_roof_ctrl: directed scenarios plus a randomized phase driving a
// simple roof plant, all checked every cycle against a queue-based model.
module tb_dht_roof_ctrl;

  localparam int N       = 4;
  localparam int STALE   = 1000;
  localparam int MTO     = 500;
  localparam int DEAD    = 20;
  localparam int T_OPEN  = 20;
  localparam int T_CLOSE = 15;
  localparam int H_OPEN  = 70;
  localparam int H_CLOSE = 85;
  localparam int TRAVEL  = 40;

  localparam int S_INIT = 0, S_CLOSED = 1, S_OPEN = 2, S_OPENING = 3,
                 S_CLOSING = 4, S_STOP = 5, S_FAULT = 6;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [7:0] i_temp = '0;
  logic [7:0] i_humi = '0;
  logic       i_valid = 1'b0;
  logic       i_lim_open = 1'b0;
  logic       i_lim_closed = 1'b0;
  logic       o_motor_open, o_motor_close, o_avg_valid, o_stale, o_fault;
  logic [7:0] o_avg_temp, o_avg_humi;
  logic [2:0] o_state;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_state, m_age, m_idle, m_seen, m_at, m_ah;
  bit m_ok, m_lo1, m_lo2, m_lc1, m_lc2;
  int qt[$];
  int qh[$];

  dht_roof_ctrl #(
    .AVG_LOG2   (2),
    .TEMP_OPEN  (8'd20),
    .TEMP_CLOSE (8'd15),
    .HUMI_OPEN  (8'd70),
    .HUMI_CLOSE (8'd85),
    .STALE_CYC  (32'd1000),
    .MOTOR_TO   (32'd500),
    .DEAD_CYC   (32'd20)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_temp        (i_temp),
    .i_humi        (i_humi),
    .i_valid       (i_valid),
    .i_lim_open    (i_lim_open),
    .i_lim_closed  (i_lim_closed),
    .o_motor_open  (o_motor_open),
    .o_motor_close (o_motor_close),
    .o_avg_temp    (o_avg_temp),
    .o_avg_humi    (o_avg_humi),
    .o_avg_valid   (o_avg_valid),
    .o_stale       (o_stale),
    .o_fault       (o_fault),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_INIT; m_age = 0; m_idle = 0; m_seen = 0;
    m_at = 0; m_ah = 0; m_ok = 0;
    m_lo1 = 0; m_lo2 = 0; m_lc1 = 0; m_lc2 = 0;
    qt.delete(); qh.delete();
  endtask

  // Advance the model by one clock edge using the values visible before it
  task automatic model_step();
    int nxt, st, sh;
    bit wc, wo, lo, lc;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    wc = (m_idle >= STALE) || (m_ok && (m_ah >= H_CLOSE || m_at <= T_CLOSE));
    wo = !wc && m_ok && (m_ah <= H_OPEN) && (m_at >= T_OPEN);
    lo = m_lo2;
    lc = m_lc2;
    nxt = m_state;
    case (m_state)
      S_INIT:    if (m_age + 1 == 3) nxt = lc ? S_CLOSED : (lo ? S_OPEN : S_CLOSING);
      S_CLOSED:  if (wo) nxt = S_OPENING;
      S_OPEN:    if (wc) nxt = S_CLOSING;
      S_OPENING: nxt = lo ? S_OPEN : wc ? S_STOP : (m_age + 1 == MTO) ? S_FAULT : S_OPENING;
      S_CLOSING: nxt = lc ? S_CLOSED : (m_age + 1 == MTO) ? S_FAULT : S_CLOSING;
      S_STOP:    if (m_age + 1 == DEAD) nxt = S_CLOSING;
      default:   nxt = S_FAULT;
    endcase
    if (m_state != S_INIT && m_state != S_FAULT && lo && lc) nxt = S_FAULT;
    m_age   = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
    if (i_valid) begin
      qt.push_back(int'(i_temp));
      qh.push_back(int'(i_humi));
      if (qt.size() > N) begin
        void'(qt.pop_front());
        void'(qh.pop_front());
      end
      st = 0; sh = 0;
      foreach (qt[i]) st += qt[i];
      foreach (qh[i]) sh += qh[i];
      m_at = st / N;
      m_ah = sh / N;
      m_seen++;
      m_ok = (m_seen >= N);
      m_idle = 0;
    end else begin
      m_idle++;
    end
    m_lo2 = m_lo1; m_lo1 = i_lim_open;
    m_lc2 = m_lc1; m_lc1 = i_lim_closed;
  endtask

  task automatic check_all();
    chk("state",     o_state,       m_state);
    chk("mot_open",  o_motor_open,  m_state == S_OPENING);
    chk("mot_close", o_motor_close, m_state == S_CLOSING);
    chk("fault",     o_fault,       m_state == S_FAULT);
    chk("avg_t",     o_avg_temp,    m_at);
    chk("avg_h",     o_avg_humi,    m_ah);
    chk("avg_valid", o_avg_valid,   m_ok);
    chk("stale",     o_stale,       m_idle >= STALE);
    chk("excl",      o_motor_open & o_motor_close, 0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int t, input int h);
    i_temp  = 8'(t);
    i_humi  = 8'(h);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_state(input int code, input int max_t, input string tag, output int n);
    n = 0;
    while (o_state !== 3'(code) && n < max_t) begin
      tick();
      n++;
    end
    chk(tag, o_state, code);
  endtask

  task automatic do_reset(input bit lo, input bit lc);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_lim_open = lo;
    i_lim_closed = lc;
    model_reset();
    #1;
    check_all();
    idle(2);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, pos;
    model_reset();
    #1;

    // reset values and INIT -> CLOSED with the closed switch made
    do_reset(1'b0, 1'b1);
    chk("rst_state", o_state, S_INIT);
    wait_state(S_CLOSED, 6, "init_closed", n);
    chk("init_cycles", n, 3);

    // window fill and open
    for (int i = 0; i < 4; i++) send(25, 50);
    chk("fill_avg_t", o_avg_temp, 25);
    chk("fill_avg_h", o_avg_humi, 50);
    chk("fill_valid", o_avg_valid, 1);
    wait_state(S_OPENING, 3, "to_opening", n);
    chk("opening_lat", n, 1);
    i_lim_closed = 1'b0;
    idle(5);
    i_lim_open = 1'b1;
    wait_state(S_OPEN, 6, "to_open", n);
    chk("open_sync_lat", n, 3);

    // rain closes the roof once the mean reaches the close threshold
    for (int i = 0; i < 3; i++) send(25, 90);
    chk("rain3_avg_h", o_avg_humi, 80);
    chk("rain3_open", o_state, S_OPEN);
    send(25, 90);
    wait_state(S_CLOSING, 3, "rain_closing", n);
    chk("rain_lat", n, 1);
    i_lim_open = 1'b0;
    i_lim_closed = 1'b1;
    wait_state(S_CLOSED, 6, "rain_closed", n);

    // hysteresis band holds position
    for (int i = 0; i < 4; i++) send(18, 80);
    for (int i = 0; i < 4; i++) send(18, 50);
    idle(10);
    chk("band_state", o_state, S_CLOSED);
    chk("band_avg_t", o_avg_temp, 18);
    chk("band_mot", {o_motor_open, o_motor_close}, 0);

    // close request while opening -> STOP dwell -> CLOSING
    for (int i = 0; i < 4; i++) send(25, 50);
    chk("reopen", o_state, S_OPENING);
    i_lim_closed = 1'b0;
    for (int i = 0; i < 4; i++) send(25, 90);
    wait_state(S_STOP, 3, "to_stop", n);
    chk("stop_lat", n, 1);
    wait_state(S_CLOSING, DEAD + 5, "stop_closing", n);
    chk("stop_dwell", n, DEAD);
    i_lim_closed = 1'b1;
    wait_state(S_CLOSED, 6, "stop_closed", n);

    // stale data fail-safe from OPEN
    for (int i = 0; i < 4; i++) send(25, 50);
    chk("st_opening", o_state, S_OPENING);
    i_lim_closed = 1'b0;
    i_lim_open = 1'b1;
    wait_state(S_OPEN, 6, "st_open", n);
    send(25, 50);
    n = 0;
    while (o_stale !== 1'b1 && n < STALE + 100) begin
      tick();
      n++;
    end
    chk("stale_cycles", n, STALE);
    wait_state(S_CLOSING, 3, "stale_closing", n);
    chk("stale_lat", n, 1);
    i_lim_open = 1'b0;
    i_lim_closed = 1'b1;
    wait_state(S_CLOSED, 6, "stale_closed", n);

    // motion timeout latches FAULT
    send(25, 50);
    chk("stale_clear", o_stale, 0);
    wait_state(S_OPENING, 3, "to_opening2", n);
    i_lim_closed = 1'b0;
    wait_state(S_FAULT, MTO + 50, "timeout_fault", n);
    chk("timeout_cycles", n, MTO);
    i_lim_closed = 1'b1;
    idle(8);
    chk("fault_sticky", o_fault, 1);

    // contradictory limits -> FAULT; reset returns to INIT
    do_reset(1'b0, 1'b1);
    chk("rst2_state", o_state, S_INIT);
    chk("rst2_fault", o_fault, 0);
    wait_state(S_CLOSED, 6, "rst2_closed", n);
    i_lim_open = 1'b1;
    wait_state(S_FAULT, 6, "both_lim_fault", n);
    chk("both_lim_lat", n, 3);

    // reset while moving drops the motor immediately
    do_reset(1'b0, 1'b0);
    wait_state(S_CLOSING, 6, "init_closing", n);
    chk("mc_on", o_motor_close, 1);
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_drop", o_motor_close, 0);
    check_all();
    idle(2);

    // randomized readings against a simple roof plant
    i_lim_closed = 1'b1;
    i_lim_open = 1'b0;
    i_rst_n = 1'b1;
    pos = 0;
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      if (gap == 0) begin
        i_temp  = 8'($urandom_range(10, 30));
        i_humi  = 8'($urandom_range(40, 95));
        i_valid = 1'b1;
        gap = $urandom_range(1, 25);
      end else begin
        i_valid = 1'b0;
        gap--;
      end
      tick();
      if (o_motor_open === 1'b1 && pos < TRAVEL) pos++;
      if (o_motor_close === 1'b1 && pos > 0) pos--;
      i_lim_open   = (pos == TRAVEL);
      i_lim_closed = (pos == 0);
    end
    i_valid = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
